// File: rtl/branch_cc_unit_pkg.sv
// ---------------------------------------------------------------
// branch_cc_unit_pkg : Bicc cond codes, FSM states, CC bit indices
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package branch_cc_unit_pkg;

  localparam logic [3:0] COND_BN   = 4'b0000;
  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BLE  = 4'b0010;
  localparam logic [3:0] COND_BL   = 4'b0011;
  localparam logic [3:0] COND_BLEU = 4'b0100;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;
  localparam logic [3:0] COND_BNE  = 4'b1001;
  localparam logic [3:0] COND_BG   = 4'b1010;
  localparam logic [3:0] COND_BGE  = 4'b1011;
  localparam logic [3:0] COND_BGU  = 4'b1100;
  localparam logic [3:0] COND_BCC  = 4'b1101;
  localparam logic [3:0] COND_BPOS = 4'b1110;
  localparam logic [3:0] COND_BVC  = 4'b1111;

  localparam int unsigned CC_N = 3;
  localparam int unsigned CC_Z = 2;
  localparam int unsigned CC_C = 1;
  localparam int unsigned CC_V = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SLOT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/branch_cc_unit_if.sv
// ---------------------------------------------------------------
// branch_cc_unit_if : pipeline <-> branch/CC unit signal bundle
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface branch_cc_unit_if;

  logic        cc_we;
  logic        alu_n;
  logic        alu_z;
  logic        alu_c;
  logic        alu_v;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic        br_annul;
  logic [31:0] br_target;
  logic        slot_valid;
  logic [3:0]  cc;
  logic        ci;
  logic        annul_slot;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output cc_we, alu_n, alu_z, alu_c, alu_v,
    output br_valid, br_cond, br_annul, br_target, slot_valid,
    input  br_ready, cc, ci, annul_slot, redirect_valid, redirect_pc
  );

  modport slave (
    input  cc_we, alu_n, alu_z, alu_c, alu_v,
    input  br_valid, br_cond, br_annul, br_target, slot_valid,
    output br_ready, cc, ci, annul_slot, redirect_valid, redirect_pc
  );

endinterface

`default_nettype wire

// File: rtl/branch_cc_unit_cond_eval.sv
// ---------------------------------------------------------------
// cond_eval : Bicc condition test against {N,Z,C,V}
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module cond_eval
  import branch_cc_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic w_base;

  // cond[3] inverts the base test for every encoding, including never/always.
  always_comb begin
    w_base = 1'b0;
    unique case (cond[2:0])
      3'b000:  w_base = 1'b0;
      3'b001:  w_base = flags[CC_Z];
      3'b010:  w_base = flags[CC_Z] | (flags[CC_N] ^ flags[CC_V]);
      3'b011:  w_base = flags[CC_N] ^ flags[CC_V];
      3'b100:  w_base = flags[CC_C] | flags[CC_Z];
      3'b101:  w_base = flags[CC_C];
      3'b110:  w_base = flags[CC_N];
      3'b111:  w_base = flags[CC_V];
      default: w_base = 1'b0;
    endcase
    taken = w_base ^ cond[3];
  end

endmodule

`default_nettype wire

// File: rtl/branch_cc_unit.sv
// ---------------------------------------------------------------
// branch_cc_unit : condition codes, Bicc resolve, delay-slot annul
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module branch_cc_unit
  import branch_cc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_cc_unit_if.slave    bus
);

  state_t      state_q, state_d;
  logic [3:0]  cc_q, cc_d;
  logic        taken_q, taken_d;
  logic        annul_q, annul_d;
  logic [31:0] target_q, target_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic [3:0]  w_alu_flags;
  logic [3:0]  w_eval_flags;
  logic        w_taken;
  logic        w_accept;

  assign w_alu_flags  = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
  // Same-cycle flag write is forwarded so the branch sees the newest CC.
  assign w_eval_flags = bus.cc_we ? w_alu_flags : cc_q;
  assign w_accept     = bus.br_valid && (state_q == ST_IDLE);

  cond_eval u_cond_eval (
    .cond  (bus.br_cond),
    .flags (w_eval_flags),
    .taken (w_taken)
  );

  always_comb begin
    state_d       = state_q;
    cc_d          = bus.cc_we ? w_alu_flags : cc_q;
    taken_d       = taken_q;
    annul_d       = annul_q;
    target_d      = target_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d  = ST_SLOT;
          taken_d  = w_taken;
          annul_d  = bus.br_annul & (~w_taken | (bus.br_cond == COND_BA));
          target_d = bus.br_target;
        end
      end
      ST_SLOT: begin
        if (bus.slot_valid) begin
          state_d = ST_IDLE;
          if (taken_q) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = target_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cc_q          <= 4'b0000;
      taken_q       <= 1'b0;
      annul_q       <= 1'b0;
      target_q      <= 32'h0000_0000;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= RESET_PC;
    end else begin
      state_q       <= state_d;
      cc_q          <= cc_d;
      taken_q       <= taken_d;
      annul_q       <= annul_d;
      target_q      <= target_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign bus.br_ready       = (state_q == ST_IDLE);
  assign bus.cc             = cc_q;
  assign bus.ci             = cc_q[CC_C];
  assign bus.annul_slot     = (state_q == ST_SLOT) && annul_q;
  assign bus.redirect_valid = redir_valid_q;
  assign bus.redirect_pc    = redir_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_cc_unit.sv
// ---------------------------------------------------------------
// tb_branch_cc_unit : directed self-checking bench for branch_cc_unit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_branch_cc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  branch_cc_unit_if bus ();

  branch_cc_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    bus.cc_we = 1'b1;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = f;
  endtask

  task automatic offer(input logic [3:0] cond, input logic a, input logic [31:0] tgt);
    bus.br_valid  = 1'b1;
    bus.br_cond   = cond;
    bus.br_annul  = a;
    bus.br_target = tgt;
  endtask

  // Per-cond taken masks (bit i = cond i) for flags 4'b1010 and 4'b0101.
  logic [15:0] mask_a;
  logic [15:0] mask_b;

  task automatic sweep(input logic [3:0] f, input logic [15:0] mask);
    set_flags(f); tick(); bus.cc_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      offer(4'(i), 1'b1, 32'h2000 + 32'(i));
      tick();
      bus.br_valid = 1'b0;
      check($sformatf("sweep_annul f=%b c=%0d", f, i), {31'd0, bus.annul_slot},
            {31'd0, ~mask[i] | (i == 8)});
      bus.slot_valid = 1'b1;
      tick();
      bus.slot_valid = 1'b0;
      check($sformatf("sweep_redir f=%b c=%0d", f, i), {31'd0, bus.redirect_valid},
            {31'd0, mask[i]});
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mask_a   = 16'h837C;
    mask_b   = 16'h619E;
    rst_n = 1'b0;
    bus.cc_we = 1'b0;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = 4'b0000;
    bus.br_valid = 1'b0; bus.br_cond = 4'd0; bus.br_annul = 1'b0;
    bus.br_target = 32'd0; bus.slot_valid = 1'b0;
    tick(); tick();
    check("rst_cc", {28'd0, bus.cc}, 32'd0);
    check("rst_redir_v", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_redir_pc", bus.redirect_pc, RST_PC);
    check("rst_ready", {31'd0, bus.br_ready}, 32'd1);
    check("rst_annul", {31'd0, bus.annul_slot}, 32'd0);
    rst_n = 1'b1;
    tick();

    // BE taken, a=0, slot withheld one cycle
    set_flags(4'b0100); tick(); bus.cc_we = 1'b0;
    check("t1_cc", {28'd0, bus.cc}, 32'h4);
    offer(4'b0001, 1'b0, 32'h0000_0100);
    tick(); bus.br_valid = 1'b0;
    check("t1_ready_slot", {31'd0, bus.br_ready}, 32'd0);
    check("t1_annul", {31'd0, bus.annul_slot}, 32'd0);
    tick();
    check("t1_no_early_redir", {31'd0, bus.redirect_valid}, 32'd0);
    bus.slot_valid = 1'b1; tick(); bus.slot_valid = 1'b0;
    check("t1_redir_v", {31'd0, bus.redirect_valid}, 32'd1);
    check("t1_redir_pc", bus.redirect_pc, 32'h100);
    tick();
    check("t1_redir_pulse", {31'd0, bus.redirect_valid}, 32'd0);
    check("t1_pc_hold", bus.redirect_pc, 32'h100);
    bus.slot_valid = 1'b1; tick(); bus.slot_valid = 1'b0;
    check("idle_slot_ignored", {31'd0, bus.redirect_valid}, 32'd0);

    // BGE with N=1,V=0 not taken, a=1
    set_flags(4'b1000); tick(); bus.cc_we = 1'b0;
    offer(4'b1011, 1'b1, 32'h200);
    tick(); bus.br_valid = 1'b0;
    check("t2_annul", {31'd0, bus.annul_slot}, 32'd1);
    bus.slot_valid = 1'b1; #1;
    check("t2_annul_slotcyc", {31'd0, bus.annul_slot}, 32'd1);
    tick(); bus.slot_valid = 1'b0;
    check("t2_no_redir", {31'd0, bus.redirect_valid}, 32'd0);
    check("t2_annul_idle", {31'd0, bus.annul_slot}, 32'd0);
    check("t2_pc_hold", bus.redirect_pc, 32'h100);

    // BA a=1
    offer(4'b1000, 1'b1, 32'h40);
    tick(); bus.br_valid = 1'b0;
    check("t3_annul", {31'd0, bus.annul_slot}, 32'd1);
    bus.slot_valid = 1'b1; tick(); bus.slot_valid = 1'b0;
    check("t3_redir_v", {31'd0, bus.redirect_valid}, 32'd1);
    check("t3_redir_pc", bus.redirect_pc, 32'h40);
    tick();

    // BCS with C forwarded; delay slot then clears CC
    check("t4_ci_before", {31'd0, bus.ci}, 32'd0);
    set_flags(4'b0010);
    offer(4'b0101, 1'b0, 32'h300);
    tick(); bus.br_valid = 1'b0; bus.cc_we = 1'b0;
    check("t4_ci", {31'd0, bus.ci}, 32'd1);
    check("t4_cc", {28'd0, bus.cc}, 32'h2);
    set_flags(4'b0000); bus.slot_valid = 1'b1;
    tick(); bus.slot_valid = 1'b0; bus.cc_we = 1'b0;
    check("t4_redir_v", {31'd0, bus.redirect_valid}, 32'd1);
    check("t4_redir_pc", bus.redirect_pc, 32'h300);
    check("t4_cc_slot", {28'd0, bus.cc}, 32'h0);
    tick();

    // Reset in SLOT with taken branch pending
    set_flags(4'b0100); tick(); bus.cc_we = 1'b0;
    offer(4'b0001, 1'b0, 32'h500);
    tick(); bus.br_valid = 1'b0;
    rst_n = 1'b0; set_flags(4'b1111); bus.slot_valid = 1'b1;
    tick();
    rst_n = 1'b1; bus.cc_we = 1'b0; bus.slot_valid = 1'b0;
    check("t5_no_redir", {31'd0, bus.redirect_valid}, 32'd0);
    check("t5_cc", {28'd0, bus.cc}, 32'd0);
    check("t5_ready", {31'd0, bus.br_ready}, 32'd1);
    check("t5_pc", bus.redirect_pc, RST_PC);
    tick();
    check("t5_no_redir_later", {31'd0, bus.redirect_valid}, 32'd0);

    // Second branch held through SLOT, accepted in redirect cycle
    offer(4'b1000, 1'b0, 32'h600);
    tick();
    offer(4'b1001, 1'b0, 32'h700);
    #1;
    check("t6_ready_slot", {31'd0, bus.br_ready}, 32'd0);
    set_flags(4'b0100); bus.slot_valid = 1'b1;
    tick(); bus.cc_we = 1'b0; bus.slot_valid = 1'b0;
    check("t6_redir_v", {31'd0, bus.redirect_valid}, 32'd1);
    check("t6_redir_pc", bus.redirect_pc, 32'h600);
    check("t6_ready_redir", {31'd0, bus.br_ready}, 32'd1);
    tick(); bus.br_valid = 1'b0;
    check("t6_accepted", {31'd0, bus.br_ready}, 32'd0);
    check("t6_pulse_end", {31'd0, bus.redirect_valid}, 32'd0);
    bus.slot_valid = 1'b1; tick(); bus.slot_valid = 1'b0;
    check("t6_bne_untaken", {31'd0, bus.redirect_valid}, 32'd0);
    check("t6_pc_hold", bus.redirect_pc, 32'h600);

    sweep(4'b1010, mask_a);
    sweep(4'b0101, mask_b);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_cc_unit.md
BRANCH_CC_UNIT -- requirements
Module: branch_cc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; value driven on redirect_pc out of reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port cc_we  input  1  ALU executed a modify-cc op this cycle.
REQ-005 SHALL have port alu_n, alu_z, alu_c, alu_v  input  1 each  ALU condition flags.
REQ-006 SHALL have port br_valid  input  1  Bicc branch offered.
REQ-007 SHALL have port br_ready  output  1  unit can accept a branch.
REQ-008 SHALL have port br_cond  input  4  condition field, encoded as Bicc cond[3:0].
REQ-009 SHALL have port br_annul  input  1  annul bit a.
REQ-010 SHALL have port br_target  input  32  branch target address.
REQ-011 SHALL have port slot_valid  input  1  delay-slot instruction leaves execute this cycle.
REQ-012 SHALL have port cc  output  4  registered {N,Z,C,V}.
REQ-013 SHALL have port ci  output  1  equals cc[1] (C); carry-in for the ALU add/sub-with-carry ops.
REQ-014 SHALL have port annul_slot  output  1  squash the delay-slot instruction.
REQ-015 SHALL have port redirect_valid  output  1  one-cycle fetch redirect pulse.
REQ-016 SHALL have port redirect_pc  output  32  redirect address.

Function
REQ-017 SHALL load cc from {alu_n,alu_z,alu_c,alu_v} on every edge with cc_we=1, in any state; otherwise cc holds.
REQ-018 SHALL evaluate conditions as follows:
- 0000 never; 1000 always.
- 0001 Z; 1001 !Z.
- 0010 Z|(N^V); 1010 !(Z|(N^V)).
- 0011 N^V; 1011 !(N^V).
- 0100 C|Z; 1100 !(C|Z).
- 0101 C; 1101 !C.
- 0110 N; 1110 !N.
- 0111 V; 1111 !V.
REQ-019 SHALL forward incoming ALU flags when cc_we and a branch accept occur in the same cycle; the branch is evaluated against the new flags, not the registered cc.
REQ-020 SHALL implement the FSM IDLE -> SLOT -> IDLE; br_ready=1 only in IDLE; a branch is accepted when br_valid & br_ready.
REQ-021 On accept, SHALL latch taken, br_target and the annul decision, and move to SLOT.
REQ-022 SHALL set the annul decision to br_annul & (!taken | cond==1000); branches that are taken and conditional never annul.
REQ-023 In SLOT, SHALL drive annul_slot to the latched annul decision combinationally; annul_slot=0 in IDLE.
REQ-024 On slot_valid in SLOT, SHALL return to IDLE.
REQ-025 On that same edge, SHALL pulse redirect_valid for exactly one cycle when taken=1, with redirect_pc = latched target.
REQ-026 Untaken branches SHALL produce no redirect.
REQ-027 slot_valid in IDLE SHALL be ignored.
REQ-028 A new br_valid in the cycle redirect_valid is high SHALL be accepted, because the FSM is already IDLE.
REQ-029 cc writes from the delay-slot instruction SHALL NOT change an already latched taken decision.
REQ-030 redirect_pc SHALL hold its last value between pulses.
REQ-031 Latency: accept to redirect_valid is at least 2 cycles; there is no upper bound while slot_valid is withheld.

Reset
REQ-032 While rst_n=0 at an edge, SHALL set cc=4'b0000, state=IDLE, redirect_valid=0, redirect_pc=RESET_PC and clear latched taken/annul.
REQ-033 Reset asserted mid-SLOT SHALL abandon the pending branch with no redirect; reset has priority over cc_we.

Structure
REQ-034 A shared package SHALL hold: the cond encodings (COND_BN..COND_BVC), the state typedef, and the CC bit indices (CC_N=3, CC_Z=2, CC_C=1, CC_V=0).
REQ-035 Condition evaluation SHALL be one combinational sub-module, cond_eval (inputs cond[3:0] and flags[3:0]; output taken), reusable by a later trap-on-condition block.

Verification
REQ-036 Bench: cc_we with flags Z=1, then BE (0001) to target 32'h0000_0100, a=0, then slot_valid -> annul_slot=0; redirect_valid one cycle with redirect_pc=32'h100.
REQ-037 Bench: cc={N=1,V=0}, BGE (1011) with a=1 -> not taken; annul_slot=1 during SLOT; no redirect_valid.
REQ-038 Bench: BA (1000) with a=1 to 32'h40 -> annul_slot=1; redirect to 32'h40 on slot_valid.
REQ-039 Bench: cc_we with C=1 in the same cycle as BCS (0101) while registered C=0 -> taken (forwarding); ci=1 from the next cycle.
REQ-040 Bench: rst_n=0 while in SLOT with a taken branch pending -> no redirect; cc=0; br_ready=1 the next cycle.
REQ-041 Bench: second br_valid held during SLOT -> br_ready=0; it is accepted in the redirect cycle and evaluated against the cc current at acceptance.
